// File: rtl/complete_arbiter.sv
// -----------------------------------------------------------------------------
// complete_arbiter
//
// Merges completions from N_REQ execution units onto the single register-file
// write-back bus. Each unit pushes into its own small FIFO. A round-robin
// arbiter pops at most one head per cycle into a registered complete bus.
// `flash` discards every pending completion.
//
// Parameters:
//   N_REQ  number of requesting units (2..8)
//   DEPTH  entries per requester FIFO (power of two, >= 2)
//
// Ports:
//   clock                in   sole clock, rising edge
//   reset                in   asynchronous active-high clear
//   flash                in   synchronous flush of all FIFOs and the bus valid
//   req_valid            in   [N_REQ]     unit i offers a completion
//   req_dest_logic       in   [8*N_REQ]   slice i: logical destination
//   req_dest_phys        in   [64*N_REQ]  slice i: physical tag
//   req_data             in   [32*N_REQ]  slice i: result data
//   req_ready            out  [N_REQ]     FIFO i not full
//   complete_en          out              complete bus valid (1-cycle pulse)
//   complete_dest_logic  out  [8]
//   complete_dest_phys   out  [64]
//   complete_data        out  [32]
//   conflict_count       out  [32]  only when COMPLETE_ARB_STATS_EN is defined:
//                                   cycles with >= 2 non-empty FIFOs
//
// Optional feature macro: COMPLETE_ARB_STATS_EN
// -----------------------------------------------------------------------------
module complete_arbiter #(
    parameter int N_REQ = 3,
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flash,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_dest_logic,
    input  logic [64*N_REQ-1:0]   req_dest_phys,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  complete_en,
    output logic [7:0]            complete_dest_logic,
    output logic [63:0]           complete_dest_phys,
    output logic [31:0]           complete_data
`ifdef COMPLETE_ARB_STATS_EN
    ,
    output logic [31:0]           conflict_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr [N_REQ];
    logic [PW-1:0] rd_ptr [N_REQ];

    logic [7:0]    mem_dl [N_REQ][DEPTH];
    logic [63:0]   mem_dp [N_REQ][DEPTH];
    logic [31:0]   mem_d  [N_REQ][DEPTH];

    logic [N_REQ-1:0] empty;
    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] push;

    logic [RW-1:0] rr;
    logic [RW-1:0] gnt_idx;
    logic [RW-1:0] rr_next;
    logic          gnt_valid;
    logic [3:0]    busy_cnt;

    // ------------------------------------------------------------------
    // FIFO status: derived from registered pointers only, so a pop in the
    // same cycle never raises ready.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] ^ rd_ptr[i]) == {1'b1, {AW{1'b0}}});
        end
    end

    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    // ------------------------------------------------------------------
    // Round-robin scan starting at rr, wrapping modulo N_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        busy_cnt  = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_valid && !empty[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = RW'(idx);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            busy_cnt = busy_cnt + {3'b000, ~empty[i]};
        end
    end

    assign rr_next = (gnt_idx == RW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // ------------------------------------------------------------------
    // Pointer state; flash has priority over push and pop.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else if (flash) begin
            for (int i = 0; i < N_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (gnt_valid && (gnt_idx == RW'(i))) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the cleared pointers mark every slot
    // invalid, so contents never escape before being written.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!flash && push[i]) begin
                mem_dl[i][wr_ptr[i][AW-1:0]] <= req_dest_logic[8*i +: 8];
                mem_dp[i][wr_ptr[i][AW-1:0]] <= req_dest_phys[64*i +: 64];
                mem_d[i][wr_ptr[i][AW-1:0]]  <= req_data[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered complete bus and round-robin pointer. Data fields hold
    // their value when nothing is granted or on flash.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr                  <= '0;
            complete_en         <= 1'b0;
            complete_dest_logic <= '0;
            complete_dest_phys  <= '0;
            complete_data       <= '0;
        end else if (flash) begin
            rr          <= '0;
            complete_en <= 1'b0;
        end else if (gnt_valid) begin
            rr                  <= rr_next;
            complete_en         <= 1'b1;
            complete_dest_logic <= mem_dl[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
            complete_dest_phys  <= mem_dp[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
            complete_data       <= mem_d[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
        end else begin
            complete_en <= 1'b0;
        end
    end

`ifdef COMPLETE_ARB_STATS_EN
    // Counts cycles with contention; survives flash, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (busy_cnt >= 4'd2) begin
            conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// -----------------------------------------------------------------------------
// tb_complete_arbiter
//
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the arbiter. Define COMPLETE_ARB_STATS_EN to also check
// conflict_count.
// -----------------------------------------------------------------------------
module tb_complete_arbiter;

    localparam int N_REQ = 3;
    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0]  dl;
        logic [63:0] dp;
        logic [31:0] d;
    } ent_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flash;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_dest_logic;
    logic [64*N_REQ-1:0]  req_dest_phys;
    logic [32*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 complete_en;
    logic [7:0]           complete_dest_logic;
    logic [63:0]          complete_dest_phys;
    logic [31:0]          complete_data;
`ifdef COMPLETE_ARB_STATS_EN
    logic [31:0]          conflict_count;
`endif

    complete_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .flash               (flash),
        .req_valid           (req_valid),
        .req_dest_logic      (req_dest_logic),
        .req_dest_phys       (req_dest_phys),
        .req_data            (req_data),
        .req_ready           (req_ready),
        .complete_en         (complete_en),
        .complete_dest_logic (complete_dest_logic),
        .complete_dest_phys  (complete_dest_phys),
        .complete_data       (complete_data)
`ifdef COMPLETE_ARB_STATS_EN
        ,
        .conflict_count      (conflict_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: one queue per unit, a round-robin start index, and
    // the last value presented on the bus.
    ent_t        q [N_REQ][$];
    int          m_rr;
    logic        m_en;
    ent_t        m_out;
    logic [31:0] m_cc;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REQ; i++) q[i].delete();
        m_rr  = 0;
        m_en  = 1'b0;
        m_out = '{dl: '0, dp: '0, d: '0};
        m_cc  = '0;
    endtask

    task automatic set_ent(input int i, input ent_t e);
        req_dest_logic[8*i +: 8]  = e.dl;
        req_dest_phys[64*i +: 64] = e.dp;
        req_data[32*i +: 32]      = e.d;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.dl = 8'($urandom);
        e.dp = {$urandom, $urandom};
        e.d  = $urandom;
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_en"},    {63'd0, complete_en}, {63'd0, m_en});
        check({tag, "_dl"},    {56'd0, complete_dest_logic}, {56'd0, m_out.dl});
        check({tag, "_dp"},    complete_dest_phys, m_out.dp);
        check({tag, "_data"},  {32'd0, complete_data}, {32'd0, m_out.d});
`ifdef COMPLETE_ARB_STATS_EN
        check({tag, "_cc"},    {32'd0, conflict_count}, {32'd0, m_cc});
`endif
    endtask

    // One clock cycle: called #1 after a rising edge with data slices already
    // set. Checks ready, advances the model at the edge, checks the bus.
    task automatic step(input logic [N_REQ-1:0] v, input logic f, input string tag);
        ent_t cur [N_REQ];
        bit   rdy [N_REQ];
        int   g, idx, ne;
        req_valid = v;
        flash     = f;
        for (int i = 0; i < N_REQ; i++) begin
            cur[i].dl = req_dest_logic[8*i +: 8];
            cur[i].dp = req_dest_phys[64*i +: 64];
            cur[i].d  = req_data[32*i +: 32];
            rdy[i]    = (q[i].size() < DEPTH);
            check($sformatf("%s_ready%0d", tag, i), {63'd0, req_ready[i]}, {63'd0, rdy[i]});
        end
        @(posedge clock);
        ne = 0;
        for (int i = 0; i < N_REQ; i++) if (q[i].size() > 0) ne++;
        if (ne >= 2) m_cc = m_cc + 32'd1;
        if (f) begin
            for (int i = 0; i < N_REQ; i++) q[i].delete();
            m_rr = 0;
            m_en = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_rr + k) % N_REQ;
                if (g < 0 && q[idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                m_out = q[g].pop_front();
                m_en  = 1'b1;
                m_rr  = (g + 1) % N_REQ;
            end else begin
                m_en = 1'b0;
            end
            for (int i = 0; i < N_REQ; i++)
                if (v[i] && rdy[i]) q[i].push_back(cur[i]);
        end
        #1;
        check_outputs(tag);
        req_valid = '0;
        flash     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ent_t e;
        reset          = 1'b1;
        flash          = 1'b0;
        req_valid      = '0;
        req_dest_logic = '0;
        req_dest_phys  = '0;
        req_data       = '0;
        model_reset();
        #1;
        check("por_en", {63'd0, complete_en}, 64'd0);
        check("por_ready", {61'd0, req_ready}, {61'd0, 3'b111});
        do_reset();
        check_outputs("reset");

        // Single push from unit 1: visible after the following edge, then gone.
        e = '{dl: 8'h05, dp: 64'd7, d: 32'hDEADBEEF};
        set_ent(1, e);
        step(3'b010, 1'b0, "single0");
        check("single_lat_en", {63'd0, complete_en}, 64'd0);
        step(3'b000, 1'b0, "single1");
        check("single_en", {63'd0, complete_en}, 64'd1);
        check("single_data", {32'd0, complete_data}, {32'd0, 32'hDEADBEEF});
        check("single_dp", complete_dest_phys, 64'd7);
        step(3'b000, 1'b0, "single2");
        check("single_drop", {63'd0, complete_en}, 64'd0);

        // Full contention from rr=0.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
            step(3'b111, 1'b0, "contend");
        end

        // Backpressure: unit 0 keeps pushing while others stay busy.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
            step(3'b111, 1'b0, "bp");
        end

        // Flash with simultaneous pushes, then idle: nothing stale appears.
        for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
        step(3'b111, 1'b1, "flash");
        check("flash_en", {63'd0, complete_en}, 64'd0);
        for (int c = 0; c < 3; c++) step(3'b000, 1'b0, "postflash");
        for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
        step(3'b111, 1'b0, "refill0");
        step(3'b000, 1'b0, "refill1");
        step(3'b000, 1'b0, "refill2");

        // Async reset mid-burst.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
            step(3'b111, 1'b0, "burst");
        end
        check("burst_en", {63'd0, complete_en}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_en",   {63'd0, complete_en}, 64'd0);
        check("areset_dl",   {56'd0, complete_dest_logic}, 64'd0);
        check("areset_dp",   complete_dest_phys, 64'd0);
        check("areset_data", {32'd0, complete_data}, 64'd0);
        check("areset_ready", {61'd0, req_ready}, {61'd0, 3'b111});
`ifdef COMPLETE_ARB_STATS_EN
        check("areset_cc", {32'd0, conflict_count}, 64'd0);
`endif
        model_reset();
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        set_ent(2, rand_ent());
        step(3'b100, 1'b0, "post_rst0");
        step(3'b000, 1'b0, "post_rst1");

        // Contention for the statistics counter, then a flash.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
            step(3'b011, 1'b0, "stats");
        end
        step(3'b000, 1'b0, "stats_flash0");
        step(3'b000, 1'b1, "stats_flash1");

        // Randomized traffic with occasional flashes.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) set_ent(i, rand_ent());
            step(N_REQ'($urandom), ($urandom_range(0, 19) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
